// File: rtl/nubus_slave_memory.sv
`default_nettype none
// ============================================================================
// Module      : nubus_slave_memory
// Description : Word-organised, byte-lane-writable RAM serving as the memory
//               target behind the NuBus slave interface. Each accepted
//               single-word request is acknowledged by a one-cycle ready
//               pulse, which the NuBus side turns into ACK.
// Ports       : mem_clk      - clock (rising edge = NuBus sampling edge)
//               mem_reset    - synchronous active-high reset
//               mem_valid    - request pending, held until ready is seen
//               mem_wstrb    - byte-lane write strobes, 0000 = read
//               mem_addr     - byte address, bits MEM_ADDR_BITS+1:2 used
//               mem_wdata    - lane-aligned write data
//               mem_myslot   - address hits this card's slot space
//               mem_myexp    - address hits this card's expansion space
//               mem_rdata_o  - read data, held until next read or reset
//               mem_ready_o  - one-cycle request-complete pulse
//               mem_write_o  - completed access was a write
// Revision    : 1.0 - initial release
// ============================================================================
module nubus_slave_memory #(
  parameter int MEM_ADDR_BITS = 8
) (
  input  logic        mem_clk,
  input  logic        mem_reset,
  input  logic        mem_valid,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_myslot,
  input  logic        mem_myexp,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        mem_write_o
);

  localparam int C_DEPTH = 2 ** MEM_ADDR_BITS;

  // Storage powers up all-zero; reset deliberately leaves it untouched.
  logic [31:0] r_mem [C_DEPTH] = '{default: '0};

  logic                     w_sel;
  logic                     w_accept;
  logic                     w_is_write;
  logic [MEM_ADDR_BITS-1:0] w_idx;

  assign w_sel      = mem_myslot | mem_myexp;
  // Gating on ~mem_ready_o forces one idle cycle after each response, so a
  // continuously held valid is serviced every second cycle. Reset wins over
  // a coincident accept, which also blocks the RAM write below.
  assign w_accept   = mem_valid & w_sel & ~mem_ready_o & ~mem_reset;
  assign w_is_write = |mem_wstrb;
  // Upper address bits are ignored, so addresses alias modulo the depth;
  // bits [1:0] are ignored because lane placement comes from the strobes.
  assign w_idx      = mem_addr[MEM_ADDR_BITS+1:2];

  // Address bits outside the index window have no function here.
  logic w_unused_addr;
  assign w_unused_addr = ^{mem_addr[31:MEM_ADDR_BITS+2], mem_addr[1:0]};

  // RAM array: per-lane strobed write, no reset.
  always_ff @(posedge mem_clk) begin
    if (w_accept && w_is_write) begin
      for (int n = 0; n < 4; n++) begin
        if (mem_wstrb[n]) begin
          r_mem[w_idx][8*n +: 8] <= mem_wdata[8*n +: 8];
        end
      end
    end
  end

  // Response registers: the ready flop is the whole handshake state
  // (0 = idle, 1 = responding).
  always_ff @(posedge mem_clk) begin
    if (mem_reset) begin
      mem_ready_o <= 1'b0;
      mem_write_o <= 1'b0;
      mem_rdata_o <= 32'h0;
    end else begin
      mem_ready_o <= w_accept;
      if (w_accept) begin
        mem_write_o <= w_is_write;
        // Reads return the full word; lane masking is the bus side's job.
        if (!w_is_write) begin
          mem_rdata_o <= r_mem[w_idx];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nubus_slave_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_nubus_slave_memory
// Description : Directed self-checking bench for nubus_slave_memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nubus_slave_memory;

  localparam logic [31:0] C_BASE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        myslot;
  logic        myexp;
  logic [31:0] rdata;
  logic        ready;
  logic        wr_flag;

  int checks = 0;
  int errors = 0;

  // Model of the last value returned on a read (rdata holds between reads).
  logic [31:0] last_rd;
  logic [31:0] rd;

  always #5 clk = ~clk;

  nubus_slave_memory #(.MEM_ADDR_BITS(8)) dut (
    .mem_clk    (clk),
    .mem_reset  (rst),
    .mem_valid  (valid),
    .mem_wstrb  (wstrb),
    .mem_addr   (addr),
    .mem_wdata  (wdata),
    .mem_myslot (myslot),
    .mem_myexp  (myexp),
    .mem_rdata_o(rdata),
    .mem_ready_o(ready),
    .mem_write_o(wr_flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One single-word access; checks ready latency, pulse width, write flag,
  // and that writes leave rdata untouched.
  task automatic access(input string tag, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic slot, input logic exp_sel,
                        output logic [31:0] r);
    @(posedge clk); #1;
    addr = a; wstrb = s; wdata = d; myslot = slot; myexp = exp_sel; valid = 1'b1;
    check({tag, "_ready_pre"}, {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_ready"}, {31'b0, ready}, 32'd1);
    check({tag, "_write"}, {31'b0, wr_flag}, {31'b0, (s != 4'b0000)});
    if (s != 4'b0000) check({tag, "_rdata_hold"}, rdata, last_rd);
    else last_rd = rdata;
    r = rdata;
    valid = 1'b0; myslot = 1'b0; myexp = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ready_drop"}, {31'b0, ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; wstrb = 4'b0; addr = '0; wdata = '0;
    myslot = 1'b0; myexp = 1'b0; last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_write", {31'b0, wr_flag}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // Full word
    access("w_word", C_BASE, 4'b1111, 32'h8765_4321, 1'b1, 1'b0, rd);
    access("r_word", C_BASE, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("word_data", rd, 32'h8765_4321);

    // Half lanes
    access("w_lo", C_BASE + 4, 4'b0011, 32'h8765_4321, 1'b1, 1'b0, rd);
    access("r_lo", C_BASE + 4, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("half_lo", rd, 32'h0000_4321);
    access("w_hi", C_BASE + 8, 4'b1100, 32'h8765_4321, 1'b1, 1'b0, rd);
    access("r_hi", C_BASE + 8, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("half_hi", rd, 32'h8765_0000);

    // Byte lanes
    access("w_b0", C_BASE + 12, 4'b0001, 32'h8765_4321, 1'b1, 1'b0, rd);
    access("w_b1", C_BASE + 16, 4'b0010, 32'h8765_4321, 1'b1, 1'b0, rd);
    access("w_b2", C_BASE + 20, 4'b0100, 32'h8765_4321, 1'b1, 1'b0, rd);
    access("w_b3", C_BASE + 24, 4'b1000, 32'h8765_4321, 1'b1, 1'b0, rd);
    access("r_b0", C_BASE + 12, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("byte0", rd, 32'h0000_0021);
    access("r_b1", C_BASE + 16, 4'b0000, 32'h0, 1'b0, 1'b1, rd);
    check("byte1", rd, 32'h0000_4300);
    access("r_b2", C_BASE + 20, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("byte2", rd, 32'h0065_0000);
    access("r_b3", C_BASE + 24, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("byte3", rd, 32'h8700_0000);

    // Merge and alias
    access("w_m0", C_BASE, 4'b1111, 32'hAAAA_AAAA, 1'b1, 1'b0, rd);
    access("w_m1", C_BASE, 4'b0001, 32'h0000_00BB, 1'b0, 1'b1, rd);
    access("r_m", C_BASE, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("merge", rd, 32'hAAAA_AABB);
    access("r_alias", C_BASE + 32'h400, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("alias", rd, 32'hAAAA_AABB);

    // Unselected write attempt: nothing happens for 5 cycles
    @(posedge clk); #1;
    addr = C_BASE; wstrb = 4'b1111; wdata = 32'hDEAD_BEEF; valid = 1'b1;
    myslot = 1'b0; myexp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("unsel_ready%0d", i), {31'b0, ready}, 32'd0);
    end
    check("unsel_rdata", rdata, 32'hAAAA_AABB);
    check("unsel_write", {31'b0, wr_flag}, 32'd0);
    valid = 1'b0;
    access("r_unsel", C_BASE, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("unsel_ram", rd, 32'hAAAA_AABB);

    // Back-to-back: valid held, ready toggles 0,1,0,1
    @(posedge clk); #1;
    addr = C_BASE + 4; wstrb = 4'b0000; myslot = 1'b1; valid = 1'b1;
    check("b2b_0", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    check("b2b_1", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    check("b2b_2", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    check("b2b_3", {31'b0, ready}, 32'd1);
    check("b2b_rdata", rdata, 32'h0000_4321);
    valid = 1'b0; myslot = 1'b0;
    @(posedge clk); #1;
    check("b2b_4", {31'b0, ready}, 32'd0);

    // Reset colliding with a write accept
    access("r_pre", C_BASE + 12, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    access("w_pre", C_BASE + 28, 4'b1111, 32'h5A5A_5A5A, 1'b1, 1'b0, rd);
    @(posedge clk); #1;
    addr = C_BASE + 12; wstrb = 4'b1111; wdata = 32'hFFFF_FFFF;
    myslot = 1'b1; valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("rstc_ready", {31'b0, ready}, 32'd0);
    check("rstc_write", {31'b0, wr_flag}, 32'd0);
    check("rstc_rdata", rdata, 32'd0);
    valid = 1'b0; myslot = 1'b0; rst = 1'b0; last_rd = 32'd0;
    access("r_post12", C_BASE + 12, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("rstc_ram", rd, 32'h0000_0021);
    access("r_post28", C_BASE + 28, 4'b0000, 32'h0, 1'b1, 1'b0, rd);
    check("rstc_keep", rd, 32'h5A5A_5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
